// File: rtl/lcd_ctrl.sv
// HD44780 write controller for a 4-bit bus.
// Takes one byte per request, sends it as one or two E pulses on DB7..DB4, then
// blocks further requests for the controller's execution time.
//
// Handshake: wr is a one-cycle request strobe with busy as the inverted ready.
// A request is taken on any rising edge where wr=1 and busy=0, including the cycle
// in which busy has just fallen. A wr seen while busy=1 is discarded and sets
// the sticky ovf flag, which only rst clears.
module lcd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EPW   = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_WAIT  = 1080,
  parameter int unsigned T_LONG  = 44280
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rs_in,
  input  logic       nib,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       ovf,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  // Each state runs for T cycles, so it is entered with count T-1. A zero
  // parameter loads 0, which gives the one-cycle minimum.
  function automatic logic [15:0] load_of(input int unsigned t);
    if (t == 0) return 16'd0;
    return 16'(t - 1);
  endfunction

  localparam logic [15:0] LD_SETUP = load_of(T_SETUP);
  localparam logic [15:0] LD_EPW   = load_of(T_EPW);
  localparam logic [15:0] LD_HOLD  = load_of(T_HOLD);
  localparam logic [15:0] LD_WAIT  = load_of(T_WAIT);
  localparam logic [15:0] LD_LONG  = load_of(T_LONG);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP_H = 3'd1,
    EHI_H   = 3'd2,
    HOLD_H  = 3'd3,
    SETUP_L = 3'd4,
    EHI_L   = 3'd5,
    HOLD_L  = 3'd6,
    WAIT    = 3'd7
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] load_val;
  logic        load;
  logic        accept;
  logic        rs_r;
  logic        nib_r;
  logic [7:0]  data_r;
  logic        long_cmd;

  // Clear display (0x01) and return home (0x02) need the long execution time.
  assign long_cmd = !rs_r && !nib_r && ((data_r == 8'h01) || (data_r == 8'h02));

  // Next state and counter reload. A state ends once its count has reached zero.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = 16'd0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (wr) begin
          accept     = 1'b1;
          state_next = SETUP_H;
          load       = 1'b1;
          load_val   = LD_SETUP;
        end
      end
      SETUP_H: begin
        if (cnt == 16'd0) begin
          state_next = EHI_H;
          load       = 1'b1;
          load_val   = LD_EPW;
        end
      end
      EHI_H: begin
        if (cnt == 16'd0) begin
          state_next = HOLD_H;
          load       = 1'b1;
          load_val   = LD_HOLD;
        end
      end
      HOLD_H: begin
        if (cnt == 16'd0) begin
          load = 1'b1;
          if (nib_r) begin
            state_next = WAIT;
            load_val   = LD_WAIT;
          end else begin
            state_next = SETUP_L;
            load_val   = LD_SETUP;
          end
        end
      end
      SETUP_L: begin
        if (cnt == 16'd0) begin
          state_next = EHI_L;
          load       = 1'b1;
          load_val   = LD_EPW;
        end
      end
      EHI_L: begin
        if (cnt == 16'd0) begin
          state_next = HOLD_L;
          load       = 1'b1;
          load_val   = LD_HOLD;
        end
      end
      HOLD_L: begin
        if (cnt == 16'd0) begin
          state_next = WAIT;
          load       = 1'b1;
          load_val   = long_cmd ? LD_LONG : LD_WAIT;
        end
      end
      WAIT: begin
        if (cnt == 16'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Shared down-counter. It reloads on every state entry and stops at zero.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= 16'd0;
    else if (load)            cnt <= load_val;
    else if (cnt != 16'd0)    cnt <= cnt - 16'd1;
  end

  // Latch the request so that the inputs may change as soon as wr drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_r   <= 1'b0;
      nib_r  <= 1'b0;
      data_r <= 8'h00;
    end else if (accept) begin
      rs_r   <= rs_in;
      nib_r  <= nib;
      data_r <= data_in;
    end
  end

  // Sticky overflow: any request that arrives outside IDLE is lost.
  always_ff @(posedge clk) begin
    if (rst)                             ovf <= 1'b0;
    else if (wr && (state != IDLE))      ovf <= 1'b1;
  end

  // Registered bus outputs. E is decoded from the next state, so it is glitch-free
  // and rises exactly on entry to an E-high state. RS/DB keep their values in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 4'h0;
    end else begin
      lcd_e <= (state_next == EHI_H) || (state_next == EHI_L);
      if (accept) begin
        lcd_rs <= rs_in;
        lcd_db <= data_in[7:4];
      end else if ((state == HOLD_H) && (state_next == SETUP_L)) begin
        lcd_db <= data_r[3:0];
      end
    end
  end

  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a cycle model built from transfer-relative timing
// arithmetic, checked on every cycle, plus a nibble scoreboard and literal
// expectations for the reference transfers.
module tb_lcd_ctrl;

  localparam int S    = 2;
  localparam int EP   = 12;
  localparam int H    = 2;
  localparam int TW   = 1080;
  localparam int TL   = 44280;
  localparam int P    = S + EP + H;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rs_in;
  logic       nib;
  logic [7:0] data_in;
  logic       busy;
  logic       ovf;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [3:0] lcd_db;

  lcd_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rs_in   (rs_in),
    .nib     (nib),
    .data_in (data_in),
    .busy    (busy),
    .ovf     (ovf),
    .lcd_e   (lcd_e),
    .lcd_rw  (lcd_rw),
    .lcd_rs  (lcd_rs),
    .lcd_db  (lcd_db)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the transfer accepted at cycle t0 defines every output at
  // cycle t0+k through fixed windows of k.
  int         cyc = 0;
  int         t0 = 0;
  logic       act = 1'b0;
  logic       m_rs = 1'b0;
  logic       m_nib = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic       busy_x = 1'b0;
  logic       ovf_x = 1'b0;
  logic       e_x = 1'b0;
  logic       rs_x = 1'b0;
  logic [3:0] db_x = 4'h0;

  always @(posedge clk) begin
    int k;
    int tot;
    int s0;
    logic r;
    logic n;
    logic a;
    logic [7:0] d;
    r  = m_rs;
    n  = m_nib;
    d  = m_d;
    s0 = t0;
    a  = act;
    if (rst) begin
      act    <= 1'b0;
      busy_x <= 1'b0;
      ovf_x  <= 1'b0;
      e_x    <= 1'b0;
      rs_x   <= 1'b0;
      db_x   <= 4'h0;
    end else begin
      if (wr) begin
        if (!busy_x) begin
          r  = rs_in;
          n  = nib;
          d  = data_in;
          s0 = cyc;
          a  = 1'b1;
        end else begin
          ovf_x <= 1'b1;
        end
      end
      act   <= a;
      t0    <= s0;
      m_rs  <= r;
      m_nib <= n;
      m_d   <= d;
      k = cyc + 1 - s0;
      if (n) tot = P + TW;
      else   tot = 2 * P + ((!r && (d == 8'h01 || d == 8'h02)) ? TL : TW);
      busy_x <= a && (k >= 1) && (k <= tot);
      e_x    <= a && (((k > S) && (k <= S + EP)) ||
                      (!n && (k > P + S) && (k <= P + S + EP)));
      if (a && k == 1) begin
        rs_x <= r;
        db_x <= d[7:4];
      end
      if (a && !n && k == P + 1) db_x <= d[3:0];
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   busy,   busy_x);
      check("ovf",    ovf,    ovf_x);
      check("lcd_e",  lcd_e,  e_x);
      check("lcd_rw", lcd_rw, 1'b0);
      check("lcd_rs", lcd_rs, rs_x);
      check("lcd_db", lcd_db, db_x);
    end
  end

  // Scoreboard: each E rising edge must present the next expected nibble
  logic [3:0] exp_q[$];
  logic       e_prev = 1'b0;
  int         pulses = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (lcd_e === 1'b1 && !e_prev) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("extra_pulse", 32'd1, 32'd0);
        end else begin
          check("nibble", lcd_db, exp_q.pop_front());
        end
      end
      e_prev = (lcd_e === 1'b1);
    end
  end

  // Driver tasks: all start and end just after a falling edge
  task automatic send(input logic r, input logic n, input logic [7:0] d);
    wr      = 1'b1;
    rs_in   = r;
    nib     = n;
    data_in = d;
    exp_q.push_back(d[7:4]);
    if (!n) exp_q.push_back(d[3:0]);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy !== 1'b0 && b < 50000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Follows one transfer from the first cycle after acceptance (k=1).
  task automatic measure(output int blen, output int np, output int r1, output int f1,
                         output int r2, output int f2, output logic zdb,
                         output logic [3:0] db16, output logic [3:0] db17,
                         output logic [3:0] db_r1, output logic rs1);
    int k = 1;
    logic pe = 1'b0;
    blen = 0; np = 0; r1 = -1; f1 = -1; r2 = -1; f2 = -1;
    zdb = 1'b0; db16 = 4'hx; db17 = 4'hx; db_r1 = 4'hx; rs1 = lcd_rs;
    while (busy === 1'b1 && k < 60000) begin
      blen++;
      if (lcd_db == 4'h0) zdb = 1'b1;
      if (k == 16) db16 = lcd_db;
      if (k == 17) db17 = lcd_db;
      if (lcd_e && !pe) begin
        np++;
        if (np == 1) begin r1 = k; db_r1 = lcd_db; end
        if (np == 2) r2 = k;
      end
      if (!lcd_e && pe) begin
        if (np == 1) f1 = k - 1;
        if (np == 2) f2 = k - 1;
      end
      pe = lcd_e;
      @(negedge clk);
      k++;
    end
    if (k >= 60000) check("measure_timeout", 32'd1, 32'd0);
  endtask

  // Directed sequence
  initial begin
    int blen, np, r1, f1, r2, f2, p0;
    logic zdb, rs1;
    logic [3:0] db16, db17, dbr1;
    logic [7:0] b2b[3];
    b2b[0] = 8'h4C; b2b[1] = 8'hCD; b2b[2] = 8'h21;
    rst = 1'b1; wr = 1'b0; rs_in = 1'b0; nib = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf",  ovf,  1'b0);
    check("rst_e",    lcd_e, 1'b0);
    check("rst_rs",   lcd_rs, 1'b0);
    check("rst_db",   lcd_db, 4'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Data byte 0x48
    send(1'b1, 1'b0, 8'h48);
    measure(blen, np, r1, f1, r2, f2, zdb, db16, db17, dbr1, rs1);
    check("data_busy_len", blen, 1112);
    check("data_pulses",   np, 2);
    check("data_rise1",    r1, 3);
    check("data_fall1",    f1, 14);
    check("data_rise2",    r2, 19);
    check("data_fall2",    f2, 30);
    check("data_db_hi",    dbr1, 4'h4);
    check("data_db16",     db16, 4'h4);
    check("data_db17",     db17, 4'h8);
    check("data_rs",       rs1, 1'b1);
    check("idle_db_hold",  lcd_db, 4'h8);
    check("idle_rs_hold",  lcd_rs, 1'b1);

    // Clear display
    send(1'b0, 1'b0, 8'h01);
    measure(blen, np, r1, f1, r2, f2, zdb, db16, db17, dbr1, rs1);
    check("clr_busy_len", blen, 44312);
    check("clr_pulses",   np, 2);
    check("clr_pw1",      f1 - r1 + 1, 12);
    check("clr_pw2",      f2 - r2 + 1, 12);
    check("clr_rs",       rs1, 1'b0);

    // Nibble-only init write
    send(1'b0, 1'b1, 8'h30);
    measure(blen, np, r1, f1, r2, f2, zdb, db16, db17, dbr1, rs1);
    check("nib_busy_len", blen, 1096);
    check("nib_pulses",   np, 1);
    check("nib_db",       dbr1, 4'h3);
    check("nib_no_zero",  zdb, 1'b0);

    // Request during a transfer, then one on the cycle busy falls
    p0 = pulses;
    send(1'b1, 1'b0, 8'h41);
    repeat (499) @(negedge clk);
    check("ovf_pre", ovf, 1'b0);
    wr = 1'b1; rs_in = 1'b1; nib = 1'b0; data_in = 8'hFF;
    @(negedge clk);
    wr = 1'b0;
    check("ovf_set", ovf, 1'b1);
    wait_idle();
    check("ovf_pulses", pulses - p0, 2);
    send(1'b1, 1'b0, 8'h42);
    check("edge_accept", busy, 1'b1);
    check("ovf_kept",    ovf,  1'b1);
    wait_idle();
    check("edge_pulses", pulses - p0, 4);

    // Reset in the middle of the lower-nibble E pulse
    send(1'b1, 1'b0, 8'h55);
    repeat (19) @(negedge clk);
    check("mid_ehil_e", lcd_e, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_e",    lcd_e, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ovf",  ovf, 1'b0);
    check("abort_db",   lcd_db, 4'h0);
    wr = 1'b1; rs_in = 1'b1; data_in = 8'h77;
    @(negedge clk);
    check("wr_with_rst", busy, 1'b0);
    rst = 1'b0; wr = 1'b0;
    @(negedge clk);
    send(1'b1, 1'b0, 8'h60);
    check("post_rst_accept", busy, 1'b1);
    wait_idle();

    // Back-to-back requests
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      send(1'b1, 1'b0, b2b[i]);
    end
    wait_idle();
    check("b2b_pulses", pulses - p0, 6);
    check("b2b_ovf",    ovf, 1'b0);
    check("b2b_db",     lcd_db, 4'h1);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_SETUP, default 2, cycles RS/DB are stable before E rises.
REQ-002 Parameter T_EPW, default 12, cycles E is held high.
REQ-003 Parameter T_HOLD, default 2, cycles RS/DB are held after E falls.
REQ-004 Parameter T_WAIT, default 1080, post-transfer wait in cycles for ordinary commands and data (40 us at 27 MHz).
REQ-005 Parameter T_LONG, default 44280, post-transfer wait in cycles for clear/home (1.64 ms at 27 MHz).
REQ-006 clk  in  1  system clock; all logic is on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 wr  in  1  one-cycle strobe that requests a transfer.
REQ-009 rs_in  in  1  register select for the request: 0 = command, 1 = data.
REQ-010 nib  in  1  1 = send the upper nibble only (4-bit init writes).
REQ-011 data_in  in  8  byte to send.
REQ-012 busy  out  1  transfer or wait in progress.
REQ-013 ovf  out  1  sticky flag: a wr arrived while busy.
REQ-014 lcd_e  out  1  HD44780 enable.
REQ-015 lcd_rw  out  1  HD44780 read/write select; always 0.
REQ-016 lcd_rs  out  1  HD44780 register select.
REQ-017 lcd_db  out  4  HD44780 data bus DB7..DB4.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP_H, EHI_H, HOLD_H, SETUP_L, EHI_L, HOLD_L and WAIT.
- A single 16-bit down-counter times every state.
REQ-019 A request SHALL be accepted only when wr=1 and the FSM is in IDLE.
- On acceptance, rs_in, nib and data_in are latched and the FSM moves to SETUP_H.
- A wr on any other cycle is dropped and sets ovf.
REQ-020 On the cycle after acceptance: busy=1, lcd_rs=latched rs, lcd_db=data[7:4], lcd_e=0.
REQ-021 Upper-nibble timing SHALL be:
- SETUP_H for T_SETUP cycles, lcd_e=0.
- EHI_H for T_EPW cycles, lcd_e=1.
- HOLD_H for T_HOLD cycles, lcd_e=0.
- lcd_db and lcd_rs stay constant throughout.
REQ-022 After HOLD_H, the FSM SHALL go to WAIT if nib=1, else to SETUP_L.
- Lower-nibble states repeat REQ-021 timing with lcd_db=data[3:0].
- lcd_db changes to data[3:0] on entry to SETUP_L.
REQ-023 The WAIT length SHALL be T_LONG if rs=0 and the byte is 0x01 or 0x02 with nib=0; otherwise T_WAIT.
REQ-024 On leaving WAIT, the FSM SHALL enter IDLE and busy SHALL drop the same cycle.
- Busy length: 2*(T_SETUP+T_EPW+T_HOLD)+wait cycles (nib=0), or (T_SETUP+T_EPW+T_HOLD)+T_WAIT cycles (nib=1).
REQ-025 In IDLE, lcd_e=0, lcd_rw=0, and lcd_rs/lcd_db SHALL hold the last driven values.
REQ-026 busy SHALL be 0 in IDLE and 1 in every other state.
- A wr in the same cycle that busy falls is accepted.
REQ-027 ovf SHALL stay set until rst; acceptance never clears it.
REQ-028 A timing parameter of 0 SHALL be treated as 1 cycle.
- The counter never wraps.

Reset
REQ-029 While rst=1, the block SHALL enter IDLE on the next edge with busy=0, ovf=0, lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db=0.
- This holds in any state, including mid-EHI with E high; no partial pulse continues.
REQ-030 A wr asserted together with rst SHALL be ignored.

Verification
REQ-031 Data byte, defaults: wr, rs_in=1, data_in=0x48, nib=0 ->
- lcd_db=4, rs=1.
- E high for cycles 3..14 after acceptance.
- lcd_db=8 from cycle 17.
- E high for cycles 19..30.
- busy high for 1112 cycles.
REQ-032 Clear command: rs_in=0, data_in=0x01 -> busy high for 44312 cycles; two E pulses of 12 cycles each.
REQ-033 Nibble init write: nib=1, data_in=0x30 -> one E pulse with lcd_db=3; busy high for 1096 cycles; lcd_db never shows 0.
REQ-034 wr at cycle 500 of a transfer -> ovf=1 and the request is ignored (no extra E pulse); wr on the cycle busy falls -> accepted, ovf unchanged.
REQ-035 rst asserted during EHI_L -> the next edge gives lcd_e=0, busy=0, ovf=0; a new wr is accepted after rst drops.
REQ-036 Back-to-back: a wr issued on every cycle that busy=0, 3 data bytes -> exactly 6 E pulses, each with correct nibble order, and ovf=0.
